hilo_acc_reg: RTL
=================

HILO_ACC_REG -- requirements
Module: hilo_acc_reg

Interface
REQ-001 SHALL have parameter DW, default 32, width of each of HI and LO in bits (legal values 8..64).
REQ-002 SHALL have parameter ACC_EN, default 1, which enables the accumulate ops when 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port we  input  1  operation request; sampled only when busy_o=0.
REQ-006 SHALL have port op  input  3  operation: 000 WR_BOTH, 001 WR_HI, 010 WR_LO, 011 MADD, 100 MSUB, 101-111 reserved.
REQ-007 SHALL have port hi_i  input  DW  HI operand or write data.
REQ-008 SHALL have port lo_i  input  DW  LO operand or write data.
REQ-009 SHALL have port hi_o  output  DW  current HI register value, registered.
REQ-010 SHALL have port lo_o  output  DW  current LO register value, registered.
REQ-011 SHALL have port busy_o  output  1  accumulate in progress; the pipeline stalls while it is 1.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse when an accumulate completes.

Function
REQ-013 SHALL accept an op at a rising edge when we=1 and busy_o=0.
REQ-014 SHALL ignore we, op, hi_i and lo_i while busy_o=1.
REQ-015 SHALL implement WR_BOTH as a single-cycle update: hi_o<=hi_i, lo_o<=lo_i.
REQ-016 SHALL implement WR_HI as a single-cycle update of HI only; LO holds.
REQ-017 SHALL implement WR_LO as a single-cycle update of LO only; HI holds.
REQ-018 SHALL treat reserved ops as no-ops: no state change and no busy.
REQ-019 SHALL treat MADD and MSUB as no-ops when ACC_EN=0.
REQ-020 SHALL implement MADD as {HI,LO} <= {HI,LO} + {hi_i,lo_i}, modulo 2^(2*DW), with overflow discarded.
REQ-021 SHALL implement MSUB as {HI,LO} <= {HI,LO} - {hi_i,lo_i}, modulo 2^(2*DW), with borrow discarded.
REQ-022 SHALL use a two-state FSM, IDLE and ACC_HI.
REQ-023 SHALL, on accepting MADD/MSUB in IDLE, write the DW-bit low-half result to LO, capture the carry (MADD: lo+lo_i; MSUB: lo+~lo_i+1), capture hi_i (inverted for MSUB), and go to ACC_HI.
REQ-024 SHALL, in ACC_HI, write HI <= HI + captured operand + captured carry, pulse done_o for that cycle, and return to IDLE.
REQ-025 SHALL drive busy_o combinationally =1 exactly in state ACC_HI, giving total accumulate latency of 2 edges with 1 stall cycle.
REQ-026 SHALL present LO with the new low half and HI with the old value for one cycle between the two accumulate edges.
REQ-027 SHALL allow back-to-back single-cycle writes on consecutive edges.
REQ-028 SHALL accept a new op in the cycle immediately after done_o.
REQ-029 SHALL, if we=1 on the same edge that completes ACC_HI, ignore that request (busy_o=1 at that edge); the source re-presents it.
REQ-030 SHALL hold all state when we=0 in IDLE.

Reset
REQ-031 SHALL, when rst=0, asynchronously force hi_o=0, lo_o=0, busy_o=0, done_o=0, FSM=IDLE, and clear the captured carry/operand, independent of clk.
REQ-032 SHALL abort an in-flight accumulate on reset; no partial HI update may occur after rst returns to 1.
REQ-033 SHALL accept the first op at the first rising edge after rst deasserts.

Verification
REQ-034 SHALL be verified with DW=32: reset, then WR_BOTH hi_i=0x12345678 lo_i=0x9ABCDEF0 -> next edge hi_o=0x12345678, lo_o=0x9ABCDEF0, busy_o=0.
REQ-035 SHALL be verified with HI=0, LO=0xFFFFFFFF, MADD hi_i=0 lo_i=1 -> edge 1: lo_o=0, hi_o=0, busy_o=1; edge 2: hi_o=1, done_o=1, busy_o=0.
REQ-036 SHALL be verified with HI=0, LO=0, MSUB hi_i=0 lo_i=1 -> after 2 edges hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF; a WR_LO presented during busy is ignored.
REQ-037 SHALL be verified with HI=0xAAAA0000, LO=5, WR_HI hi_i=7 then WR_LO lo_i=9 on consecutive edges -> hi_o=7, lo_o=9, no busy; op=110 -> no change.
REQ-038 SHALL be verified by asserting rst=0 between edge 1 and edge 2 of MADD -> hi_o=lo_o=0 immediately, busy_o=0, and HI stays 0 after release.
REQ-039 SHALL be verified with ACC_EN=0: MADD hi_i=1 lo_i=1 -> no state change, busy_o never asserts.

Source files
------------

// File: rtl/hilo_acc_reg.sv
// HI/LO register pair with single-cycle writes and a
// two-edge multiply-accumulate style add/subtract path.
module hilo_acc_reg #(
  parameter int DW     = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2:0]    op,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [2:0] OP_WR_BOTH = 3'b000;
  localparam logic [2:0] OP_WR_HI   = 3'b001;
  localparam logic [2:0] OP_WR_LO   = 3'b010;
  localparam logic [2:0] OP_MADD    = 3'b011;
  localparam logic [2:0] OP_MSUB    = 3'b100;

  typedef enum logic {
    IDLE   = 1'b0,
    ACC_HI = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic          carry_q, carry_d;
  logic          done_q, done_d;

  logic          is_wr_both;
  logic          is_wr_hi;
  logic          is_wr_lo;
  logic          is_acc;
  logic          is_sub;
  logic [DW-1:0] lo_b;
  logic [DW:0]   lo_sum;
  logic [DW-1:0] hi_sum;

  // Decode the request and form both halves of the accumulate datapath.
  always_comb begin
    is_wr_both = (op == OP_WR_BOTH);
    is_wr_hi   = (op == OP_WR_HI);
    is_wr_lo   = (op == OP_WR_LO);
    is_sub     = (op == OP_MSUB);
    is_acc     = ACC_EN && ((op == OP_MADD) || is_sub);
    lo_b       = is_sub ? ~lo_i : lo_i;
    lo_sum     = {1'b0, lo_q} + {1'b0, lo_b}
               + {{DW{1'b0}}, is_sub};
    hi_sum     = hi_q + opnd_q
               + {{(DW-1){1'b0}}, carry_q};
  end

  // Next-state and register-update logic; reserved ops fall to default.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (we) begin
          unique case (1'b1)
            is_wr_both: begin
              hi_d = hi_i;
              lo_d = lo_i;
            end
            is_wr_hi: hi_d = hi_i;
            is_wr_lo: lo_d = lo_i;
            is_acc: begin
              lo_d    = lo_sum[DW-1:0];
              carry_d = lo_sum[DW];
              opnd_d  = is_sub ? ~hi_i : hi_i;
              state_d = ACC_HI;
            end
            default: ;
          endcase
        end
      end
      ACC_HI: begin
        hi_d    = hi_sum;
        carry_d = 1'b0;
        opnd_d  = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also discards any half-finished accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q == ACC_HI);
  assign done_o = done_q;

endmodule
